// File: rtl/vstu_addrgen_if.sv
// Bundle of request, AXI AW and store-unit queue signals for the vector store address generator.
// The master modport is the address generator; the slave modport is its environment.
interface vstu_addrgen_if #(
    parameter int AxiAddrWidth = 64
);
    typedef struct packed {
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic                    is_load;
    } addrgen_axi_req_t;

    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [AxiAddrWidth-1:0] req_addr_i;
    logic [31:0]             req_bytes_i;

    logic                    axi_aw_valid_o;
    logic                    axi_aw_ready_i;
    logic [AxiAddrWidth-1:0] axi_aw_addr_o;
    logic [7:0]              axi_aw_len_o;
    logic [2:0]              axi_aw_size_o;
    logic [1:0]              axi_aw_burst_o;

    addrgen_axi_req_t        addrgen_req_o;
    logic                    addrgen_req_valid_o;
    logic                    addrgen_req_ready_i;
    logic                    busy_o;

    modport master (
        input  req_valid_i, req_addr_i, req_bytes_i, axi_aw_ready_i, addrgen_req_ready_i,
        output req_ready_o, axi_aw_valid_o, axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o,
               axi_aw_burst_o, addrgen_req_o, addrgen_req_valid_o, busy_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_bytes_i, axi_aw_ready_i, addrgen_req_ready_i,
        input  req_ready_o, axi_aw_valid_o, axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o,
               axi_aw_burst_o, addrgen_req_o, addrgen_req_valid_o, busy_o
    );
endinterface

// File: rtl/vstu_addrgen.sv
// Splits unit-stride vector store requests into AXI INCR write bursts that never cross 4 KiB
// or exceed 256 beats, and mirrors every issued burst into a FIFO for the store unit.
module vstu_addrgen #(
    parameter int AxiDataWidth = 64,
    parameter int AxiAddrWidth = 64,
    parameter int QueueDepth   = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    vstu_addrgen_if.master bus
);
    localparam int          Bw            = AxiDataWidth / 8;
    localparam int          SizeLog       = $clog2(Bw);
    localparam int          PtrW          = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
    localparam int          CntW          = $clog2(QueueDepth + 1);
    localparam logic [31:0] MaxBurstBytes = 32'(256 * Bw);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [AxiAddrWidth-1:0] curAddr_q, curAddr_d;
    logic [31:0]             rem_q, rem_d;

    logic [AxiAddrWidth-1:0] qAddr_q [QueueDepth];
    logic [7:0]              qLen_q  [QueueDepth];
    logic [PtrW-1:0]         wrPtr_q, rdPtr_q;
    logic [CntW-1:0]         count_q;

    logic [31:0] offset, toBoundary, maxFromOffset, chunk, span;
    logic [7:0]  burstLen;
    logic        full, empty, awValid, push, pop;

    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
        return (p == PtrW'(QueueDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Largest legal chunk: bounded by remaining bytes, the 4 KiB page and 256 beats from the aligned start.
    always_comb begin
        offset        = 32'(curAddr_q[SizeLog-1:0]);
        toBoundary    = 32'd4096 - 32'(curAddr_q[11:0]);
        maxFromOffset = MaxBurstBytes - offset;
        chunk         = rem_q;
        if (toBoundary < chunk) chunk = toBoundary;
        if (maxFromOffset < chunk) chunk = maxFromOffset;
        span          = offset + chunk + 32'(Bw - 1);
        burstLen      = 8'((span >> SizeLog) - 32'd1);
    end

    assign full    = (count_q == CntW'(QueueDepth));
    assign empty   = (count_q == '0);
    assign awValid = (state_q == SPLIT) && !full;
    assign push    = awValid && bus.axi_aw_ready_i;
    assign pop     = !empty && bus.addrgen_req_ready_i;

    always_comb begin
        state_d   = state_q;
        curAddr_d = curAddr_q;
        rem_d     = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i && (bus.req_bytes_i != 32'd0)) begin
                    state_d   = SPLIT;
                    curAddr_d = bus.req_addr_i;
                    rem_d     = bus.req_bytes_i;
                end
            end
            default: begin
                if (push) begin
                    curAddr_d = curAddr_q + AxiAddrWidth'(chunk);
                    rem_d     = rem_q - chunk;
                    if (rem_q == chunk) state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            curAddr_q <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            curAddr_q <= curAddr_d;
            rem_q     <= rem_d;
        end
    end

    // Push and pop never collide on a full queue because AW is withheld while full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < QueueDepth; i++) begin
                qAddr_q[i] <= '0;
                qLen_q[i]  <= '0;
            end
        end else begin
            if (push) begin
                qAddr_q[wrPtr_q] <= curAddr_q;
                qLen_q[wrPtr_q]  <= burstLen;
                wrPtr_q          <= nextPtr(wrPtr_q);
            end
            if (pop) rdPtr_q <= nextPtr(rdPtr_q);
            if (push && !pop) count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
        end
    end

    assign bus.req_ready_o    = (state_q == IDLE);
    assign bus.axi_aw_valid_o = awValid;
    assign bus.axi_aw_addr_o  = (state_q == SPLIT) ? curAddr_q : '0;
    assign bus.axi_aw_len_o   = (state_q == SPLIT) ? burstLen : 8'd0;
    assign bus.axi_aw_size_o  = (state_q == SPLIT) ? 3'(SizeLog) : 3'd0;
    assign bus.axi_aw_burst_o = 2'b01;

    assign bus.addrgen_req_valid_o = !empty;
    assign bus.busy_o              = (state_q == SPLIT) || !empty;

    always_comb begin
        bus.addrgen_req_o = '0;
        if (!empty) begin
            bus.addrgen_req_o.addr = qAddr_q[rdPtr_q];
            bus.addrgen_req_o.len  = qLen_q[rdPtr_q];
            bus.addrgen_req_o.size = 3'(SizeLog);
        end
    end
endmodule

// File: tb/tb_vstu_addrgen.sv
// Scoreboard bench for vstu_addrgen: a burst-splitting model predicts AWs and queue entries,
// negedge monitors compare them, and scenario tasks check the fixed corner cases.
module tb_vstu_addrgen;
    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } burst_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cycle;

    burst_t expAw[$];
    burst_t expQ[$];
    burst_t seenAw[$];
    int     awCycle[$];
    burst_t monAw;
    burst_t monQ;

    vstu_addrgen_if #(.AxiAddrWidth(64)) bus ();

    vstu_addrgen #(
        .AxiDataWidth(64),
        .AxiAddrWidth(64),
        .QueueDepth  (2)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Monitors sample at the falling edge, when inputs for the coming rising edge are stable.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.axi_aw_valid_o && bus.axi_aw_ready_i) begin
                seenAw.push_back('{addr: bus.axi_aw_addr_o, len: bus.axi_aw_len_o});
                awCycle.push_back(cycle);
                checks++;
                if (expAw.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL aw_unexpected: got addr %0h len %0d, required no AW",
                             bus.axi_aw_addr_o, bus.axi_aw_len_o);
                end else begin
                    monAw = expAw.pop_front();
                    if (bus.axi_aw_addr_o !== monAw.addr || bus.axi_aw_len_o !== monAw.len ||
                        bus.axi_aw_size_o !== 3'd3 || bus.axi_aw_burst_o !== 2'b01) begin
                        errors++;
                        $display("[TB] FAIL aw_fields: got addr %0h len %0d size %0d burst %0d, required addr %0h len %0d size 3 burst 1",
                                 bus.axi_aw_addr_o, bus.axi_aw_len_o, bus.axi_aw_size_o,
                                 bus.axi_aw_burst_o, monAw.addr, monAw.len);
                    end
                    expQ.push_back(monAw);
                end
            end
            if (bus.addrgen_req_valid_o && bus.addrgen_req_ready_i) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL queue_unexpected: got addr %0h, required empty queue",
                             bus.addrgen_req_o.addr);
                end else begin
                    monQ = expQ.pop_front();
                    if (bus.addrgen_req_o.addr !== monQ.addr || bus.addrgen_req_o.len !== monQ.len ||
                        bus.addrgen_req_o.size !== 3'd3 || bus.addrgen_req_o.is_load !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL queue_entry: got addr %0h len %0d size %0d load %0b, required addr %0h len %0d size 3 load 0",
                                 bus.addrgen_req_o.addr, bus.addrgen_req_o.len, bus.addrgen_req_o.size,
                                 bus.addrgen_req_o.is_load, monQ.addr, monQ.len);
                    end
                end
            end
        end
    end

    // Reference split: end each burst at the earliest of request end, next 4 KiB page, or 256 beats.
    task automatic modelRequest(input logic [63:0] addr, input logic [31:0] bytes);
        logic [63:0] a;
        logic [63:0] stop;
        logic [63:0] lim;
        logic [31:0] r;
        a = addr;
        r = bytes;
        while (r != 0) begin
            stop = a + 64'(r);
            lim  = {a[63:12], 12'h000} + 64'h1000;
            if (lim < stop) stop = lim;
            lim  = {a[63:3], 3'b000} + 64'd2048;
            if (lim < stop) stop = lim;
            expAw.push_back('{addr: a, len: 8'(((stop + 64'd7) >> 3) - (a >> 3) - 64'd1)});
            r = r - 32'(stop - a);
            a = stop;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendReq(input logic [63:0] addr, input logic [31:0] bytes);
        int t;
        t = 0;
        while (!bus.req_ready_o && t < 1000) begin
            tick();
            t++;
        end
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_ready_timeout: got %b, required 1", bus.req_ready_o);
        end
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        bus.req_bytes_i = bytes;
        modelRequest(addr, bytes);
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while ((bus.busy_o || expAw.size() != 0 || expQ.size() != 0) && t < 2000) begin
            tick();
            t++;
        end
        checks++;
        if (bus.busy_o !== 1'b0 || expAw.size() != 0 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got busy %b pendingAw %0d pendingQ %0d, required 0 0 0",
                     bus.busy_o, expAw.size(), expQ.size());
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checks++;
        if (bus.req_ready_o !== 1'b1 || bus.axi_aw_valid_o !== 1'b0 || bus.addrgen_req_valid_o !== 1'b0 ||
            bus.busy_o !== 1'b0 || bus.axi_aw_addr_o !== 64'd0 || bus.axi_aw_len_o !== 8'd0 ||
            bus.axi_aw_size_o !== 3'd0 || bus.addrgen_req_o !== '0) begin
            errors++;
            $display("[TB] FAIL %s: got ready %b awv %b qv %b busy %b awaddr %0h len %0d size %0d req %0h, required 1 0 0 0 0 0 0 0",
                     tag, bus.req_ready_o, bus.axi_aw_valid_o, bus.addrgen_req_valid_o, bus.busy_o,
                     bus.axi_aw_addr_o, bus.axi_aw_len_o, bus.axi_aw_size_o, bus.addrgen_req_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checkIdleOutputs("reset_values");
        rst_n = 1'b1;
        tick();
        checkIdleOutputs("after_release");
    endtask

    task automatic test_single();
        seenAw.delete();
        awCycle.delete();
        bus.axi_aw_ready_i      = 1'b1;
        bus.addrgen_req_ready_i = 1'b1;
        sendReq(64'h1000, 32'd64);
        checks++;
        if (bus.axi_aw_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_aw_latency: got aw_valid %b, required 1", bus.axi_aw_valid_o);
        end
        waitDrain();
        checks++;
        if (seenAw.size() != 1 || seenAw[0].addr !== 64'h1000 || seenAw[0].len !== 8'd7) begin
            errors++;
            $display("[TB] FAIL single_burst: got %0d AWs first %0h/%0d, required 1 AW 1000/7",
                     seenAw.size(), seenAw.size() > 0 ? seenAw[0].addr : 64'd0,
                     seenAw.size() > 0 ? seenAw[0].len : 8'd0);
        end
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_idle: got req_ready %b, required 1", bus.req_ready_o);
        end
    endtask

    task automatic test_pair(input string tag, input logic [63:0] addr, input logic [31:0] bytes,
                             input logic [63:0] a0, input logic [7:0] l0,
                             input logic [63:0] a1, input logic [7:0] l1, input bit needAdjacent);
        seenAw.delete();
        awCycle.delete();
        sendReq(addr, bytes);
        waitDrain();
        checks++;
        if (seenAw.size() != 2) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d AWs, required 2", tag, seenAw.size());
        end else begin
            if (seenAw[0].addr !== a0 || seenAw[0].len !== l0 || seenAw[1].addr !== a1 || seenAw[1].len !== l1) begin
                errors++;
                $display("[TB] FAIL %s_bursts: got %0h/%0d %0h/%0d, required %0h/%0d %0h/%0d", tag,
                         seenAw[0].addr, seenAw[0].len, seenAw[1].addr, seenAw[1].len, a0, l0, a1, l1);
            end
            if (needAdjacent) begin
                checks++;
                if (awCycle[1] - awCycle[0] != 1) begin
                    errors++;
                    $display("[TB] FAIL %s_adjacent: got gap %0d cycles, required 1", tag, awCycle[1] - awCycle[0]);
                end
            end
        end
    endtask

    task automatic test_unaligned();
        seenAw.delete();
        sendReq(64'h1003, 32'd8);
        waitDrain();
        checks++;
        if (seenAw.size() != 1 || seenAw[0].addr !== 64'h1003 || seenAw[0].len !== 8'd1) begin
            errors++;
            $display("[TB] FAIL unaligned: got %0d AWs first %0h/%0d, required 1 AW 1003/1",
                     seenAw.size(), seenAw.size() > 0 ? seenAw[0].addr : 64'd0,
                     seenAw.size() > 0 ? seenAw[0].len : 8'd0);
        end
    endtask

    task automatic test_backpressure();
        seenAw.delete();
        bus.addrgen_req_ready_i = 1'b0;
        sendReq(64'h0, 32'd6144);
        repeat (6) tick();
        checks++;
        if (seenAw.size() != 2 || bus.axi_aw_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_stall: got AWs %0d aw_valid %b busy %b, required 2 0 1",
                     seenAw.size(), bus.axi_aw_valid_o, bus.busy_o);
        end
        bus.addrgen_req_ready_i = 1'b1;
        tick();
        bus.addrgen_req_ready_i = 1'b0;
        checks++;
        if (bus.axi_aw_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resume_after_pop: got aw_valid %b, required 1", bus.axi_aw_valid_o);
        end
        bus.addrgen_req_ready_i = 1'b1;
        waitDrain();
        checks++;
        if (seenAw.size() != 3 || seenAw[2].addr !== 64'h1000 || seenAw[2].len !== 8'd255) begin
            errors++;
            $display("[TB] FAIL third_burst: got %0d AWs, last %0h/%0d, required 3 AWs, last 1000/255",
                     seenAw.size(), seenAw.size() > 0 ? seenAw[seenAw.size()-1].addr : 64'd0,
                     seenAw.size() > 0 ? seenAw[seenAw.size()-1].len : 8'd0);
        end
    endtask

    task automatic test_zero_bytes();
        sendReq(64'h40, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.axi_aw_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL zero_bytes: got aw_valid %b busy %b ready %b, required 0 0 1",
                         bus.axi_aw_valid_o, bus.busy_o, bus.req_ready_o);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_split();
        bus.axi_aw_ready_i      = 1'b1;
        bus.addrgen_req_ready_i = 1'b0;
        sendReq(64'h0, 32'd4096);
        tick();
        checks++;
        if (bus.busy_o !== 1'b1 || bus.addrgen_req_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_split_setup: got busy %b qvalid %b, required 1 1",
                     bus.busy_o, bus.addrgen_req_valid_o);
        end
        rst_n = 1'b0;
        #1;
        expAw.delete();
        expQ.delete();
        checkIdleOutputs("reset_mid_split");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkIdleOutputs("post_reset_quiet");
        end
        bus.addrgen_req_ready_i = 1'b1;
    endtask

    initial begin
        checks                  = 0;
        errors                  = 0;
        cycle                   = 0;
        rst_n                   = 1'b0;
        bus.req_valid_i         = 1'b0;
        bus.req_addr_i          = '0;
        bus.req_bytes_i         = '0;
        bus.axi_aw_ready_i      = 1'b0;
        bus.addrgen_req_ready_i = 1'b0;

        test_reset();
        test_single();
        test_pair("cross_4k", 64'h1FF8, 32'd16, 64'h1FF8, 8'd0, 64'h2000, 8'd0, 1'b0);
        test_pair("back_to_back", 64'h0, 32'd4096, 64'h0, 8'd255, 64'h800, 8'd255, 1'b1);
        test_unaligned();
        test_backpressure();
        test_zero_bytes();
        test_reset_mid_split();
        test_pair("after_reset", 64'h0FFC, 32'd12, 64'h0FFC, 8'd0, 64'h1000, 8'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
